id_stage_pipe: RTL

//  Parametrised, registered decode stage for the OpenMIPS core, sitting between the IF/ID and ID/EX boundaries.

---
 rtl/id_stage_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered OpenMIPS decode stage with N-source forwarding, load-use stall
// and valid/ready issue into ID/EX. Define ID_ARITH_EN to also decode the add/sub/slt family.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FWD_N  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             inst_i,
  output logic                    reg1_read_o,
  output logic                    reg2_read_o,
  output logic [ADDR_W-1:0]       reg1_addr_o,
  output logic [ADDR_W-1:0]       reg2_addr_o,
  input  logic [DATA_W-1:0]       reg1_data_i,
  input  logic [DATA_W-1:0]       reg2_data_i,
  input  logic [FWD_N-1:0]        fwd_wreg_i,
  input  logic [FWD_N*ADDR_W-1:0] fwd_wd_i,
  input  logic [FWD_N*DATA_W-1:0] fwd_wdata_i,
  input  logic                    ex_is_load_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [7:0]              aluop_o,
  output logic [2:0]              alusel_o,
  output logic [DATA_W-1:0]       reg1_o,
  output logic [DATA_W-1:0]       reg2_o,
  output logic [ADDR_W-1:0]       wd_o,
  output logic                    wreg_o,
  output logic [31:0]             pc_o,
  output logic                    inst_invalid_o,
  output logic [15:0]             stall_cnt_o
);

  // state    | meaning
  // S_EMPTY  | no instruction latched
  // S_HOLD   | instruction latched, decoding / waiting to issue
  // S_HAZARD | load-use wait on fwd source 0
  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_HAZARD} state_t;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_PREF    = 6'b110011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MTLO = 6'b010011;

  localparam logic [7:0] OP_NOP  = 8'b00000000;
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_SLLV = 8'b00000100;
  localparam logic [7:0] OP_SRLV = 8'b00000110;
  localparam logic [7:0] OP_SRAV = 8'b00000111;
  localparam logic [7:0] OP_MOVZ = 8'b00001010;
  localparam logic [7:0] OP_MOVN = 8'b00001011;
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MTHI = 8'b00010001;
  localparam logic [7:0] OP_MFLO = 8'b00010010;
  localparam logic [7:0] OP_MTLO = 8'b00010011;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

`ifdef ID_ARITH_EN
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [7:0] OP_ADD   = 8'b00100000;
  localparam logic [7:0] OP_ADDU  = 8'b00100001;
  localparam logic [7:0] OP_SUB   = 8'b00100010;
  localparam logic [7:0] OP_SUBU  = 8'b00100011;
  localparam logic [7:0] OP_SLT   = 8'b00101010;
  localparam logic [7:0] OP_SLTU  = 8'b00101011;
  localparam logic [7:0] OP_ADDI  = 8'b01010101;
  localparam logic [7:0] OP_ADDIU = 8'b01010110;
  localparam logic [2:0] RES_ARITH = 3'b100;
`endif

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, inst_q, inst_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [31:0]       pc_out_q, pc_out_d;
  logic              invalid_q, invalid_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic [5:0]        opcode, funct;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_wreg, dec_rd1, dec_rd2, dec_invalid, dec_movn, dec_movz;
  logic [ADDR_W-1:0] dec_wd;
  logic [DATA_W-1:0] dec_imm, op1, op2;
  logic              wreg_n, busy, hazard, can_issue, issue, take;

  assign opcode = inst_q[31:26];
  assign funct  = inst_q[5:0];
  assign rs     = ADDR_W'(inst_q[25:21]);
  assign rt     = ADDR_W'(inst_q[20:16]);
  assign rd     = ADDR_W'(inst_q[15:11]);
  assign busy   = (state_q != S_EMPTY);

  always_comb begin
    dec_aluop   = OP_NOP;
    dec_alusel  = RES_NOP;
    dec_wreg    = 1'b0;
    dec_wd      = rd;
    dec_rd1     = 1'b0;
    dec_rd2     = 1'b0;
    dec_imm     = '0;
    dec_invalid = 1'b1;
    dec_movn    = 1'b0;
    dec_movz    = 1'b0;
    case (opcode)
      OPC_SPECIAL: begin
        dec_invalid = 1'b0;
        dec_wreg    = 1'b1;
        dec_rd1     = 1'b1;
        dec_rd2     = 1'b1;
        case (funct)
          FN_AND:  begin dec_aluop = OP_AND;  dec_alusel = RES_LOGIC; end
          FN_OR:   begin dec_aluop = OP_OR;   dec_alusel = RES_LOGIC; end
          FN_XOR:  begin dec_aluop = OP_XOR;  dec_alusel = RES_LOGIC; end
          FN_NOR:  begin dec_aluop = OP_NOR;  dec_alusel = RES_LOGIC; end
          FN_SLLV: begin dec_aluop = OP_SLLV; dec_alusel = RES_SHIFT; end
          FN_SRLV: begin dec_aluop = OP_SRLV; dec_alusel = RES_SHIFT; end
          FN_SRAV: begin dec_aluop = OP_SRAV; dec_alusel = RES_SHIFT; end
          // shift amount comes from the sa field through operand 1
          FN_SLL: begin dec_aluop = OP_SLL; dec_alusel = RES_SHIFT; dec_rd1 = 1'b0; dec_imm = DATA_W'(inst_q[10:6]); end
          FN_SRL: begin dec_aluop = OP_SRL; dec_alusel = RES_SHIFT; dec_rd1 = 1'b0; dec_imm = DATA_W'(inst_q[10:6]); end
          FN_SRA: begin dec_aluop = OP_SRA; dec_alusel = RES_SHIFT; dec_rd1 = 1'b0; dec_imm = DATA_W'(inst_q[10:6]); end
          FN_MOVN: begin dec_aluop = OP_MOVN; dec_alusel = RES_MOVE; dec_movn = 1'b1; end
          FN_MOVZ: begin dec_aluop = OP_MOVZ; dec_alusel = RES_MOVE; dec_movz = 1'b1; end
          FN_MFHI: begin dec_aluop = OP_MFHI; dec_alusel = RES_MOVE; dec_rd1 = 1'b0; dec_rd2 = 1'b0; end
          FN_MFLO: begin dec_aluop = OP_MFLO; dec_alusel = RES_MOVE; dec_rd1 = 1'b0; dec_rd2 = 1'b0; end
          FN_MTHI: begin dec_aluop = OP_MTHI; dec_wreg = 1'b0; dec_rd2 = 1'b0; end
          FN_MTLO: begin dec_aluop = OP_MTLO; dec_wreg = 1'b0; dec_rd2 = 1'b0; end
          FN_SYNC: begin dec_wreg = 1'b0; dec_rd1 = 1'b0; dec_rd2 = 1'b0; end
`ifdef ID_ARITH_EN
          FN_ADD:  begin dec_aluop = OP_ADD;  dec_alusel = RES_ARITH; end
          FN_ADDU: begin dec_aluop = OP_ADDU; dec_alusel = RES_ARITH; end
          FN_SUB:  begin dec_aluop = OP_SUB;  dec_alusel = RES_ARITH; end
          FN_SUBU: begin dec_aluop = OP_SUBU; dec_alusel = RES_ARITH; end
          FN_SLT:  begin dec_aluop = OP_SLT;  dec_alusel = RES_ARITH; end
          FN_SLTU: begin dec_aluop = OP_SLTU; dec_alusel = RES_ARITH; end
`endif
          default: begin dec_invalid = 1'b1; dec_wreg = 1'b0; dec_rd1 = 1'b0; dec_rd2 = 1'b0; end
        endcase
      end
      OPC_ANDI: begin dec_invalid = 1'b0; dec_aluop = OP_AND; dec_alusel = RES_LOGIC; dec_wreg = 1'b1;
                      dec_wd = rt; dec_rd1 = 1'b1; dec_imm = DATA_W'(inst_q[15:0]); end
      OPC_ORI:  begin dec_invalid = 1'b0; dec_aluop = OP_OR;  dec_alusel = RES_LOGIC; dec_wreg = 1'b1;
                      dec_wd = rt; dec_rd1 = 1'b1; dec_imm = DATA_W'(inst_q[15:0]); end
      OPC_XORI: begin dec_invalid = 1'b0; dec_aluop = OP_XOR; dec_alusel = RES_LOGIC; dec_wreg = 1'b1;
                      dec_wd = rt; dec_rd1 = 1'b1; dec_imm = DATA_W'(inst_q[15:0]); end
      OPC_LUI:  begin dec_invalid = 1'b0; dec_aluop = OP_OR;  dec_alusel = RES_LOGIC; dec_wreg = 1'b1;
                      dec_wd = rt; dec_rd1 = 1'b1; dec_imm = DATA_W'({inst_q[15:0], 16'h0000}); end
      OPC_PREF: dec_invalid = 1'b0;
`ifdef ID_ARITH_EN
      OPC_ADDI:  begin dec_invalid = 1'b0; dec_aluop = OP_ADDI;  dec_alusel = RES_ARITH; dec_wreg = 1'b1;
                       dec_wd = rt; dec_rd1 = 1'b1; dec_imm = {{(DATA_W-16){inst_q[15]}}, inst_q[15:0]}; end
      OPC_ADDIU: begin dec_invalid = 1'b0; dec_aluop = OP_ADDIU; dec_alusel = RES_ARITH; dec_wreg = 1'b1;
                       dec_wd = rt; dec_rd1 = 1'b1; dec_imm = {{(DATA_W-16){inst_q[15]}}, inst_q[15:0]}; end
      OPC_SLTI:  begin dec_invalid = 1'b0; dec_aluop = OP_SLT;   dec_alusel = RES_ARITH; dec_wreg = 1'b1;
                       dec_wd = rt; dec_rd1 = 1'b1; dec_imm = {{(DATA_W-16){inst_q[15]}}, inst_q[15:0]}; end
      OPC_SLTIU: begin dec_invalid = 1'b0; dec_aluop = OP_SLTU;  dec_alusel = RES_ARITH; dec_wreg = 1'b1;
                       dec_wd = rt; dec_rd1 = 1'b1; dec_imm = {{(DATA_W-16){inst_q[15]}}, inst_q[15:0]}; end
`endif
      default: ;
    endcase
  end

  // scan oldest to youngest so the lowest matching index wins
  always_comb begin
    op1 = reg1_data_i;
    op2 = reg2_data_i;
    for (int k = FWD_N-1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (fwd_wd_i[k*ADDR_W +: ADDR_W] == rs)) op1 = fwd_wdata_i[k*DATA_W +: DATA_W];
      if (fwd_wreg_i[k] && (fwd_wd_i[k*ADDR_W +: ADDR_W] == rt)) op2 = fwd_wdata_i[k*DATA_W +: DATA_W];
    end
    if (rs == '0) op1 = '0;
    if (rt == '0) op2 = '0;
    if (!dec_rd1) op1 = dec_imm;
    if (!dec_rd2) op2 = dec_imm;
    wreg_n = dec_wreg;
    if (dec_movn) wreg_n = (op2 != '0);
    if (dec_movz) wreg_n = (op2 == '0);
  end

  assign hazard = busy && ex_is_load_i && fwd_wreg_i[0] &&
                  ((dec_rd1 && (rs != '0) && (fwd_wd_i[ADDR_W-1:0] == rs)) ||
                   (dec_rd2 && (rt != '0) && (fwd_wd_i[ADDR_W-1:0] == rt)));
  assign can_issue  = !out_valid_q || out_ready_i;
  // a cleared hazard issues straight from S_HAZARD so a load-use costs one bubble
  assign issue      = busy && !hazard && can_issue;
  assign in_ready_o = rst && ((state_q == S_EMPTY) || issue);
  assign take       = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (take) state_d = S_HOLD;
      S_HOLD, S_HAZARD: begin
        if (issue)       state_d = take ? S_HOLD : S_EMPTY;
        else if (hazard) state_d = S_HAZARD;
        else             state_d = S_HOLD;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) state_d = S_EMPTY;
  end

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    pc_out_d    = pc_out_q;
    invalid_d   = invalid_q;
    out_valid_d = out_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (take && !flush_i) begin
      pc_d   = pc_i;
      inst_d = inst_i;
    end
    if (issue && !flush_i) begin
      aluop_d   = dec_aluop;
      alusel_d  = dec_alusel;
      reg1_d    = op1;
      reg2_d    = op2;
      wd_d      = dec_wd;
      wreg_d    = wreg_n;
      pc_out_d  = pc_q;
      invalid_d = dec_invalid;
    end
    if (flush_i)          out_valid_d = 1'b0;
    else if (issue)       out_valid_d = 1'b1;
    else if (out_ready_i) out_valid_d = 1'b0;
    if ((state_q == S_HAZARD) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      pc_q        <= '0;
      inst_q      <= '0;
      out_valid_q <= 1'b0;
      aluop_q     <= OP_NOP;
      alusel_q    <= RES_NOP;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      pc_out_q    <= '0;
      invalid_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      out_valid_q <= out_valid_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      pc_out_q    <= pc_out_d;
      invalid_q   <= invalid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign reg1_read_o    = busy && dec_rd1;
  assign reg2_read_o    = busy && dec_rd2;
  assign reg1_addr_o    = rs;
  assign reg2_addr_o    = rt;
  assign out_valid_o    = out_valid_q;
  assign aluop_o        = aluop_q;
  assign alusel_o       = alusel_q;
  assign reg1_o         = reg1_q;
  assign reg2_o         = reg2_q;
  assign wd_o           = wd_q;
  assign wreg_o         = wreg_q;
  assign pc_o           = pc_out_q;
  assign inst_invalid_o = invalid_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule
